// File: rtl/normaliza_arredonda.sv
// Normalise/round stage of the FP16 adder: iterative left normalisation, round-to-nearest-even, pack.
// Optional rounding is enabled by defining ARREDONDAMENTO_EN; otherwise the fraction is truncated.
module normaliza_arredonda #(
  parameter int LARG_EXP  = 5,
  parameter int LARG_MANT = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   sinal_in,
  input  logic [LARG_EXP-1:0]    expoente_in,
  input  logic [LARG_MANT+3:0]   soma_in,
  output logic                   ocupado,
  output logic                   controle,
  output logic                   sinal,
  output logic [LARG_EXP-1:0]    expoente,
  output logic [LARG_MANT-1:0]   mantissa,
  output logic                   inf,
  output logic [2:0]             estado_dbg
);

  localparam int LS = LARG_MANT + 4;
  localparam int LE = LARG_EXP + 1;
  localparam logic [LE-1:0] EXP_MAX = LE'((1 << LARG_EXP) - 1);
  localparam logic [LE-1:0] EXP_UM  = LE'(1);

  // Handshake: iniciar is taken only in OCIOSO; controle pulses once per accepted
  // operation, and ocupado covers every cycle between acceptance and that pulse.
  typedef enum logic [2:0] {OCIOSO, AJUSTE, NORMALIZA, ARREDONDA, FIM} estado_t;

  estado_t         estado;
  logic [LS-1:0]   sm;
  logic [LE-1:0]   e;
  logic            s;
  logic            ovf;

  logic [LE-1:0]   e_ajuste;
  logic            inc;
  logic [LARG_MANT+1:0] arred;
  logic [LE-1:0]   e_arred;
  logic            pode_deslocar;

  assign estado_dbg = estado;

  // Subnormal operands carry an effective exponent of 1 before any carry adjustment.
  always_comb begin
    e_ajuste = (e == '0) ? EXP_UM : e;
    if (sm[LS-1])
      e_ajuste = e_ajuste + EXP_UM;
  end

`ifdef ARREDONDAMENTO_EN
  logic guarda, pegajoso;
  assign guarda   = sm[1];
  assign pegajoso = sm[0];
  assign inc      = guarda & (pegajoso | sm[2]);
`else
  assign inc = 1'b0;
`endif

  assign arred   = {1'b0, sm[LS-2:2]} + {{(LARG_MANT+1){1'b0}}, inc};
  assign e_arred = e + {{(LE-1){1'b0}}, arred[LARG_MANT+1]};

  assign pode_deslocar = !sm[LS-2] && (e > EXP_UM) && (sm != '0) && !ovf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      sm       <= '0;
      e        <= '0;
      s        <= 1'b0;
      ovf      <= 1'b0;
      ocupado  <= 1'b0;
      controle <= 1'b0;
      sinal    <= 1'b0;
      expoente <= '0;
      mantissa <= '0;
      inf      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          controle <= 1'b0;
          if (iniciar) begin
            sm      <= soma_in;
            e       <= {1'b0, expoente_in};
            s       <= sinal_in;
            ovf     <= 1'b0;
            inf     <= 1'b0;
            ocupado <= 1'b1;
            estado  <= AJUSTE;
          end
        end
        AJUSTE: begin
          // Carry out of the adder: shift right, folding the lost bit into sticky.
          if (sm[LS-1])
            sm <= {1'b0, sm[LS-1:2], sm[1] | sm[0]};
          e      <= e_ajuste;
          ovf    <= (e_ajuste >= EXP_MAX);
          estado <= NORMALIZA;
        end
        NORMALIZA: begin
          if (pode_deslocar) begin
            sm <= {sm[LS-2:1], 1'b0, sm[0]};
            e  <= e - EXP_UM;
          end else begin
            estado <= ARREDONDA;
          end
        end
        ARREDONDA: begin
          sinal    <= s;
          controle <= 1'b1;
          ocupado  <= 1'b0;
          estado   <= FIM;
          if (sm == '0) begin
            expoente <= '0;
            mantissa <= '0;
          end else if (ovf || (e_arred >= EXP_MAX)) begin
            expoente <= EXP_MAX[LARG_EXP-1:0];
            mantissa <= '0;
            inf      <= 1'b1;
          end else if (arred[LARG_MANT+1]) begin
            expoente <= e_arred[LARG_EXP-1:0];
            mantissa <= '0;
          end else if (!arred[LARG_MANT]) begin
            expoente <= '0;
            mantissa <= arred[LARG_MANT-1:0];
          end else begin
            // Also covers a subnormal rounding into the hidden bit, where e is already 1.
            expoente <= e[LARG_EXP-1:0];
            mantissa <= arred[LARG_MANT-1:0];
          end
        end
        FIM: begin
          controle <= 1'b0;
          estado   <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_normaliza_arredonda.sv
// Scoreboard bench for normaliza_arredonda: directed vectors, expected queue, decoupled monitor.
// Expected values follow the ARREDONDAMENTO_EN build setting.
module tb_normaliza_arredonda;

  localparam int W = 17;  // {inf, sinal, expoente[4:0], mantissa[9:0]}
`ifdef ARREDONDAMENTO_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic        sinal_in = 1'b0;
  logic [4:0]  expoente_in = '0;
  logic [13:0] soma_in = '0;
  logic        ocupado, controle, sinal, inf;
  logic [4:0]  expoente;
  logic [9:0]  mantissa;
  logic [2:0]  estado_dbg;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           cyc = 0;
  int           acc_cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  normaliza_arredonda dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .sinal_in(sinal_in),
    .expoente_in(expoente_in), .soma_in(soma_in), .ocupado(ocupado),
    .controle(controle), .sinal(sinal), .expoente(expoente), .mantissa(mantissa),
    .inf(inf), .estado_dbg(estado_dbg)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic i, input logic sg, input logic [4:0] ex,
                                      input logic [9:0] mt);
    return {i, sg, ex, mt};
  endfunction

  // Monitor: pops one expectation per controle pulse, then checks the outputs are held.
  logic [W-1:0] ultimo;
  bit           hold_chk = 0;
  always @(negedge clock) begin
    if (reset && hold_chk) begin
      chk("hold_outputs", {15'd0, inf, sinal, expoente, mantissa}, {15'd0, ultimo});
      chk("controle_one_cycle", {31'd0, controle}, 32'd0);
    end
    hold_chk = 0;
    if (reset && controle) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_controle", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] esp;
        int lat;
        esp = exp_q.pop_front();
        lat = lat_q.pop_front();
        chk("result", {15'd0, inf, sinal, expoente, mantissa}, {15'd0, esp});
        chk("latency", cyc - acc_cyc, lat);
        chk("ocupado_at_controle", {31'd0, ocupado}, 32'd0);
        ultimo = esp;
        hold_chk = 1;
      end
    end
  end

  // Driver: issue one operation, optionally pulse iniciar while busy, wait (bounded) for completion.
  task automatic run_op(input logic sg, input logic [4:0] ex, input logic [13:0] soma,
                        input logic [W-1:0] esperado, input int n, input bit pulso);
    bit feito;
    @(negedge clock);
    sinal_in = sg; expoente_in = ex; soma_in = soma; iniciar = 1'b1;
    exp_q.push_back(esperado);
    lat_q.push_back(3 + n);
    @(posedge clock); #1;
    iniciar = 1'b0;
    acc_cyc = cyc;
    chk("ocupado_after_accept", {31'd0, ocupado}, 32'd1);
    chk("inf_cleared_on_accept", {31'd0, inf}, 32'd0);
    if (pulso) begin
      @(negedge clock); soma_in = 14'h2000; expoente_in = 5'd1; iniciar = 1'b1;
      @(negedge clock); iniciar = 1'b0;
    end
    feito = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (exp_q.size() == 0) begin
        feito = 1;
        break;
      end
    end
    if (!feito) begin
      chk("timeout_waiting_controle", 32'd1, 32'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
    chk("reset_controle", {31'd0, controle}, 32'd0);
    chk("reset_outputs", {15'd0, inf, sinal, expoente, mantissa}, 32'd0);
    @(negedge clock); reset = 1'b1;

    run_op(1'b0, 5'd15, 14'h0000, pk(1'b0, 1'b0, 5'd0,  10'h000), 0, 0);
    run_op(1'b0, 5'd15, 14'h2000, pk(1'b0, 1'b0, 5'd16, 10'h000), 0, 0);
    run_op(1'b1, 5'd15, 14'h0100, pk(1'b0, 1'b1, 5'd11, 10'h000), 4, 0);
    run_op(1'b0, 5'd15, 14'h1FFE, RND ? pk(1'b0, 1'b0, 5'd16, 10'h000)
                                      : pk(1'b0, 1'b0, 5'd15, 10'h3FF), 0, 0);
    run_op(1'b0, 5'd30, 14'h2000, pk(1'b1, 1'b0, 5'd31, 10'h000), 0, 0);
    run_op(1'b0, 5'd0,  14'h0404, pk(1'b0, 1'b0, 5'd0,  10'h101), 0, 0);
    run_op(1'b0, 5'd0,  14'h0FFE, RND ? pk(1'b0, 1'b0, 5'd1, 10'h000)
                                      : pk(1'b0, 1'b0, 5'd0, 10'h3FF), 0, 0);
    run_op(1'b1, 5'd10, 14'h1002, pk(1'b0, 1'b1, 5'd10, 10'h000), 0, 0);
    run_op(1'b0, 5'd20, 14'h1007, RND ? pk(1'b0, 1'b0, 5'd20, 10'h002)
                                      : pk(1'b0, 1'b0, 5'd20, 10'h001), 0, 0);
    run_op(1'b0, 5'd30, 14'h1FFE, RND ? pk(1'b1, 1'b0, 5'd31, 10'h000)
                                      : pk(1'b0, 1'b0, 5'd30, 10'h3FF), 0, 0);
    run_op(1'b0, 5'd3,  14'h0100, pk(1'b0, 1'b0, 5'd0,  10'h100), 2, 0);
    run_op(1'b1, 5'd20, 14'h0002, pk(1'b0, 1'b1, 5'd9,  10'h000), 11, 1);
    run_op(1'b0, 5'd31, 14'h1000, pk(1'b1, 1'b0, 5'd31, 10'h000), 0, 0);
    run_op(1'b1, 5'd15, 14'h0100, pk(1'b0, 1'b1, 5'd11, 10'h000), 4, 0);

    // Reset mid-operation: accepted at edge k, reset sampled low at edge k+4.
    @(negedge clock);
    sinal_in = 1'b1; expoente_in = 5'd15; soma_in = 14'h0100; iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("midreset_ocupado", {31'd0, ocupado}, 32'd0);
    chk("midreset_controle", {31'd0, controle}, 32'd0);
    chk("midreset_outputs", {15'd0, inf, sinal, expoente, mantissa}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("no_controle_after_reset", {31'd0, controle}, 32'd0);
    run_op(1'b0, 5'd15, 14'h0100, pk(1'b0, 1'b0, 5'd11, 10'h000), 4, 0);

    repeat (3) @(posedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
